// File: rtl/clks_alot_p.sv
// Types and constants shared by the clks_alot generation and recovery paths.
package clks_alot_p;

  localparam int unsigned RATE_WIDTH_DEFAULT = 16;

  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
    logic any_edge;
  } generated_events_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_e;

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle used by every clks_alot block.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter holding the cycles left in the current phase,
// counting the current cycle; saturates at 1 and never wraps.
module phase_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] remaining,
  output logic             last_cycle
);

  logic [WIDTH-1:0] remaining_next;

  always_comb begin
    remaining_next = remaining;
    if (clear) begin
      remaining_next = '0;
    end else if (load) begin
      remaining_next = load_value;
    end else if (remaining > WIDTH'(1)) begin
      remaining_next = remaining - WIDTH'(1);
    end
  end

  // last_cycle is registered alongside the count so it is valid in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining  <= '0;
      last_cycle <= 1'b0;
    end else begin
      remaining  <= remaining_next;
      last_cycle <= (remaining_next == WIDTH'(1));
    end
  end

endmodule

// File: rtl/clk_generation.sv
// Programmable high/low clock synthesizer emitting expected and preemptive
// edge events; all outputs are registered and valid in the cycle they describe.
module clk_generation
  import clks_alot_p::*;
#(
  parameter int unsigned RATE_WIDTH = clks_alot_p::RATE_WIDTH_DEFAULT
) (
  input  common_p::clk_dom_s     sys_dom_i,
  input  logic                   generation_en_i,
  input  logic                   clear_state_i,
  input  logic [RATE_WIDTH-1:0]  high_rate_i,
  input  logic [RATE_WIDTH-1:0]  low_rate_i,
  input  logic                   rate_update_i,
  input  logic [RATE_WIDTH-1:0]  preemptive_lead_i,
  output logic                   generated_clk_o,
  output generated_events_s      expected_clks_o,
  output generated_events_s      preemetive_clks_o,
  output logic                   active_o,
  output logic                   rate_error_o
);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  gen_state_e state;
  gen_state_e state_next;

  logic [RATE_WIDTH-1:0] act_high;
  logic [RATE_WIDTH-1:0] act_low;
  logic [RATE_WIDTH-1:0] pend_high;
  logic [RATE_WIDTH-1:0] pend_low;
  logic                  pend_valid;

  logic [RATE_WIDTH-1:0] remaining;
  logic                  last_cycle;
  logic                  cnt_clear;
  logic                  cnt_load;
  logic [RATE_WIDTH-1:0] cnt_value;

  logic                  rate_ok;
  logic                  update_ok;
  logic [RATE_WIDTH-1:0] idle_high;
  logic [RATE_WIDTH-1:0] idle_low;
  logic [RATE_WIDTH-1:0] wrap_high;
  logic                  lead_hit;
  logic                  rise_next;
  logic                  first_rise_next;
  logic                  fall_next;
  generated_events_s     exp_next;
  generated_events_s     pre_next;

  phase_counter #(.WIDTH(RATE_WIDTH)) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (cnt_value),
    .remaining  (remaining),
    .last_cycle (last_cycle)
  );

  // An update accepted while idle takes effect at once, so it may start the clock
  always_comb begin
    rate_ok   = (high_rate_i != '0) && (low_rate_i != '0);
    update_ok = rate_update_i && rate_ok;
    idle_high = update_ok ? high_rate_i : act_high;
    idle_low  = update_ok ? low_rate_i  : act_low;
    wrap_high = pend_valid ? pend_high : act_high;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    if (clear_state_i) begin
      state_next = IDLE;
      cnt_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (generation_en_i && (idle_high != '0) && (idle_low != '0)) begin
            state_next = HIGH;
            cnt_load   = 1'b1;
            cnt_value  = idle_high;
          end
        end
        HIGH: begin
          if (last_cycle) begin
            state_next = LOW;
            cnt_load   = 1'b1;
            cnt_value  = act_low;
          end
        end
        LOW: begin
          if (last_cycle) begin
            if (generation_en_i) begin
              state_next = HIGH;
              cnt_load   = 1'b1;
              cnt_value  = wrap_high;
            end else begin
              state_next = IDLE;
              cnt_clear  = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end
      endcase
    end
  end

  // Pending rates apply when LOW ends; an update in that same cycle waits a period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_high   <= '0;
      act_low    <= '0;
      pend_high  <= '0;
      pend_low   <= '0;
      pend_valid <= 1'b0;
    end else if (clear_state_i) begin
      act_high   <= '0;
      act_low    <= '0;
      pend_high  <= '0;
      pend_low   <= '0;
      pend_valid <= 1'b0;
    end else begin
      if ((state == LOW) && last_cycle && pend_valid) begin
        act_high   <= pend_high;
        act_low    <= pend_low;
        pend_valid <= 1'b0;
      end
      if (update_ok) begin
        if (state == IDLE) begin
          act_high   <= high_rate_i;
          act_low    <= low_rate_i;
          pend_valid <= 1'b0;
        end else begin
          pend_high  <= high_rate_i;
          pend_low   <= low_rate_i;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  // Preemptive hit is judged on the next-cycle count; a long lead clamps to phase start
  always_comb begin
    first_rise_next = (state == IDLE) && (state_next == HIGH);
    rise_next       = (state == LOW)  && (state_next == HIGH);
    fall_next       = (state == HIGH) && (state_next == LOW);
    lead_hit        = cnt_load ? (preemptive_lead_i >= cnt_value)
                               : ((remaining - RATE_WIDTH'(1)) == preemptive_lead_i);

    exp_next.rising_edge  = rise_next || first_rise_next;
    exp_next.falling_edge = fall_next;
    exp_next.any_edge     = rise_next || first_rise_next || fall_next;

    if (preemptive_lead_i == '0) begin
      pre_next.rising_edge  = rise_next;
      pre_next.falling_edge = fall_next;
    end else begin
      pre_next.rising_edge  = (state_next == LOW) && lead_hit && generation_en_i;
      pre_next.falling_edge = (state_next == HIGH) && lead_hit;
    end
    pre_next.any_edge = pre_next.rising_edge || pre_next.falling_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      generated_clk_o   <= 1'b0;
      expected_clks_o   <= '0;
      preemetive_clks_o <= '0;
      active_o          <= 1'b0;
      rate_error_o      <= 1'b0;
    end else begin
      generated_clk_o   <= (state_next == HIGH);
      expected_clks_o   <= exp_next;
      preemetive_clks_o <= pre_next;
      active_o          <= (state_next != IDLE);
      rate_error_o      <= !clear_state_i && rate_update_i && !rate_ok;
    end
  end

endmodule
